// File: rtl/alu_pkg.sv
// Shared definitions for the ALU write-back stage: opcodes, FSM states and
// opcode classification helpers.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NREGS  = 64;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_MOV   = 6'b000000;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'b000010;
  localparam logic [OP_W-1:0] OP_STORE = 6'b000011;
  localparam logic [OP_W-1:0] OP_ADD   = 6'b000100;
  localparam logic [OP_W-1:0] OP_MUL   = 6'b000111;
  localparam logic [OP_W-1:0] OP_LRSH  = 6'b010000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WRITE_HI = 2'd2
  } wb_state_t;

  // ADD..LRSH form one contiguous opcode range that commits to the register file.
  function automatic logic op_writes(input logic [OP_W-1:0] opcode);
    return (opcode >= OP_ADD) && (opcode <= OP_LRSH);
  endfunction

  function automatic logic op_is_mul(input logic [OP_W-1:0] opcode);
    return opcode == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_writeback_regfile.sv
// 64 x 16 general register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear of the whole array.
module regfile_64x16
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NREGS  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: latches one ALU result per handshake and commits it to
// the shared register file (MUL takes two cycles). Optional macro ALU_WB_BYPASS_EN
// forwards the in-flight write to the read ports.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NREGS  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_opcode,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [ADDR_W-1:0]   in_rdst1,
  input  logic [ADDR_W-1:0]   in_rdst2,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                wb_valid,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data
);

  wb_state_t           state;
  logic [5:0]          op_q;
  logic [2*DATA_W-1:0] result_q;
  logic [ADDR_W-1:0]   rdst1_q;
  logic [ADDR_W-1:0]   rdst2_q;
  logic                accept;
  logic [DATA_W-1:0]   arr_a;
  logic [DATA_W-1:0]   arr_b;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:     in_ready = 1'b1;
      WRITE:    in_ready = !op_is_mul(op_q);
      WRITE_HI: in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Non-writing opcodes are still latched on accept, but steer back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      rdst1_q  <= '0;
      rdst2_q  <= '0;
    end else begin
      if (accept) begin
        op_q     <= in_opcode;
        result_q <= in_result;
        rdst1_q  <= in_rdst1;
        rdst2_q  <= in_rdst2;
      end
      case (state)
        IDLE: begin
          if (accept && op_writes(in_opcode)) state <= WRITE;
        end
        WRITE: begin
          if (op_is_mul(op_q))                     state <= WRITE_HI;
          else if (accept && op_writes(in_opcode)) state <= WRITE;
          else                                     state <= IDLE;
        end
        WRITE_HI: begin
          if (accept && op_writes(in_opcode)) state <= WRITE;
          else                                state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state)
      WRITE: begin
        wb_valid = 1'b1;
        wb_addr  = rdst1_q;
        wb_data  = result_q[DATA_W-1:0];
      end
      WRITE_HI: begin
        wb_valid = 1'b1;
        wb_addr  = rdst2_q;
        wb_data  = result_q[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  regfile_64x16 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_valid),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (arr_a),
    .rdata_b (arr_b)
  );

`ifdef ALU_WB_BYPASS_EN
  assign rd_data_a = (wb_valid && (wb_addr == rd_addr_a)) ? wb_data : arr_a;
  assign rd_data_b = (wb_valid && (wb_addr == rd_addr_b)) ? wb_data : arr_b;
`else
  assign rd_data_a = arr_a;
  assign rd_data_b = arr_b;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: a scoreboard queue of expected register
// writes is filled as ops are issued and drained by a write-port monitor.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [31:0] in_result = '0;
  logic [5:0]  in_rdst1 = '0;
  logic [5:0]  in_rdst2 = '0;
  logic [5:0]  rd_addr_a = '0;
  logic [5:0]  rd_addr_b = '0;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic [15:0] wb_data;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  localparam logic [5:0] T_ADD  = 6'b000100;
  localparam logic [5:0] T_MUL  = 6'b000111;
  localparam logic [5:0] T_XOR  = 6'b001001;
  localparam logic [5:0] T_LOAD = 6'b000010;

  alu_writeback #(.DATA_W(16), .ADDR_W(6), .NREGS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_result (in_result),
    .in_rdst1  (in_rdst1),
    .in_rdst2  (in_rdst2),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wb_addr, wb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data) begin
          n_err++;
          $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_addr, wb_data, e.addr, e.data);
        end
      end
    end
  end

  // Issue one op at the current negedge once in_ready allows; returns at the
  // negedge after the accepting edge, leaving in_valid high.
  task automatic send(input logic [5:0] op, input logic [31:0] res,
                      input logic [5:0] d1, input logic [5:0] d2);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = res;
    in_rdst1  = d1;
    in_rdst2  = d2;
    if (op >= 6'd4 && op <= 6'd16) exp_q.push_back('{addr: d1, data: res[15:0]});
    if (op == 6'd7)                exp_q.push_back('{addr: d2, data: res[31:16]});
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || wb_addr !== 6'd0 || wb_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b wbv=%b addr=%0d data=%h, required 1 0 0 0000",
               in_ready, wb_valid, wb_addr, wb_data);
    end
    for (int r = 0; r < 64; r++) begin
      rd_addr_b = 6'(r);
      #1;
      n_cmp++;
      if (rd_data_b !== 16'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h, required 0000", r, rd_data_b);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    send(T_ADD, 32'h0000_1234, 6'd5, 6'd0);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_addr !== 6'd5 || wb_data !== 16'h1234) begin
      n_err++;
      $display("FAIL add_wb: got v=%b addr=%0d data=%h, required 1 5 1234", wb_valid, wb_addr, wb_data);
    end
    idle_cycles(1);
    rd_addr_b = 6'd5;
    #1;
    n_cmp++;
    if (rd_data_b !== 16'h1234) begin
      n_err++;
      $display("FAIL add_r5: got %h, required 1234", rd_data_b);
    end
  endtask

  task automatic test_mul();
    send(T_MUL, 32'hABCD_1234, 6'd3, 6'd4);
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || wb_addr !== 6'd3) begin
      n_err++;
      $display("FAIL mul_write_lo: got rdy=%b addr=%0d, required 0 3", in_ready, wb_addr);
    end
    @(negedge clk);
    rd_addr_b = 6'd3;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || wb_addr !== 6'd4 || rd_data_b !== 16'h1234) begin
      n_err++;
      $display("FAIL mul_write_hi: got rdy=%b addr=%0d r3=%h, required 1 4 1234",
               in_ready, wb_addr, rd_data_b);
    end
    @(negedge clk);
    rd_addr_b = 6'd4;
    #1;
    n_cmp++;
    if (rd_data_b !== 16'hABCD || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mul_r4: got r4=%h wbv=%b, required abcd 0", rd_data_b, wb_valid);
    end
  endtask

  task automatic test_mul_same_dest();
    send(T_MUL, 32'h0001_FFFF, 6'd7, 6'd7);
    idle_cycles(3);
    rd_addr_b = 6'd7;
    #1;
    n_cmp++;
    if (rd_data_b !== 16'h0001) begin
      n_err++;
      $display("FAIL mul_same_r7: got %h, required 0001", rd_data_b);
    end
  endtask

  task automatic test_drop();
    send(T_ADD, 32'h0000_5555, 6'd9, 6'd0);
    idle_cycles(2);
    send(T_LOAD, 32'h0000_AAAA, 6'd9, 6'd9);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (wb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drop_wbv_c%0d: got %b, required 0", c, wb_valid);
      end
      @(negedge clk);
    end
    rd_addr_b = 6'd9;
    #1;
    n_cmp++;
    if (rd_data_b !== 16'h5555) begin
      n_err++;
      $display("FAIL drop_r9: got %h, required 5555", rd_data_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a;
    send(T_ADD, 32'h0000_0BAD, 6'd2, 6'd0);
    idle_cycles(2);
    rd_addr_a = 6'd2;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready%0d: got %b, required 1", i, in_ready);
      end
      send(T_XOR, {16'h0, 16'(i * 16'h1111)}, 6'(i), 6'd0);
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 6'(i)) begin
        n_err++;
        $display("FAIL b2b_wb%0d: got v=%b addr=%0d, required 1 %0d", i, wb_valid, wb_addr, i);
      end
      if (i == 2) begin
`ifdef ALU_WB_BYPASS_EN
        exp_a = 16'h2222;
`else
        exp_a = 16'h0BAD;
`endif
        #1;
        n_cmp++;
        if (rd_data_a !== exp_a) begin
          n_err++;
          $display("FAIL b2b_read_r2: got %h, required %h", rd_data_a, exp_a);
        end
      end
    end
    idle_cycles(1);
    n_cmp++;
    if (wb_valid !== 1'b0 || rd_data_a !== 16'h2222) begin
      n_err++;
      $display("FAIL b2b_end: got wbv=%b r2=%h, required 0 2222", wb_valid, rd_data_a);
    end
  endtask

  task automatic test_reset_mid();
    send(T_MUL, 32'hBEEF_CAFE, 6'd10, 6'd11);
    in_valid = 1'b0;
    @(negedge clk);
    rd_addr_b = 6'd10;
    #1;
    n_cmp++;
    if (rd_data_b !== 16'hCAFE || wb_addr !== 6'd11) begin
      n_err++;
      $display("FAIL mid_lo_committed: got r10=%h addr=%0d, required cafe 11", rd_data_b, wb_addr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got rdy=%b wbv=%b, required 1 0", in_ready, wb_valid);
    end
    for (int r = 0; r < 64; r++) begin
      rd_addr_b = 6'(r);
      #1;
      n_cmp++;
      if (rd_data_b !== 16'h0) begin
        n_err++;
        $display("FAIL mid_reset_reg%0d: got %h, required 0000", r, rd_data_b);
      end
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mul_same_dest();
    test_drop();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
